// File: rtl/timing_control_gen2.sv
// Carrier-pulse timing controller: per-second carrier phase counter, second/minute counters and
// delayed byte-enable BRAM write strobes. Optional `MINUTE_SYNC_EN adds a minute_sync realignment input.
module timing_control_gen2 #(
  parameter int CNT_W          = 17,
  parameter int SEC_W          = 6,
  parameter int SECONDS_MINUTE = 59,
  parameter int DECIM_LOG2     = 10,
  parameter int WR_DELAY       = 3,
  parameter int MIN_WR_DELAY   = 4,
  parameter int BE_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MINUTE_SYNC_EN
  input  logic             minute_sync,
`endif
  input  logic             msf_carrier_pulse,
  input  logic [CNT_W-1:0] msf_frequency,
  input  logic [CNT_W-1:0] low_time,
  output logic [CNT_W-1:0] msf_carrier_counter,
  output logic [SEC_W-1:0] second_counter,
  output logic             one_sec_marker,
  output logic             minute_wrap,
  output logic [BE_W-1:0]  write_second_bram,
  output logic [BE_W-1:0]  write_minute_bram
);

  typedef enum logic [2:0] {IDLE, TICK, WAIT, WRITE, HOLD} state_t;

  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SECONDS_MINUTE);
  localparam logic [3:0]       WAIT_LOAD = 4'(MIN_WR_DELAY - 1);

  state_t             state, state_nxt;
  logic [3:0]         wait_cnt, wait_nxt;
  logic [SEC_W-1:0]   sec_nxt;
  logic               marker_nxt, wrap_nxt;
  logic               min_we, min_we_nxt;
  logic               match, tap, sync_now, tick_now;
  logic [WR_DELAY-1:0] tap_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msf_carrier_counter <= '0;
    end else if (msf_carrier_pulse) begin
      if (msf_carrier_counter < msf_frequency)
        msf_carrier_counter <= msf_carrier_counter + 1'b1;
      else
        msf_carrier_counter <= '0;
    end
  end

  // The tap looks at the phase before this pulse's increment.
  generate
    if (DECIM_LOG2 == 0) begin : g_tap_all
      assign tap = msf_carrier_pulse;
    end else begin : g_tap_decim
      assign tap = msf_carrier_pulse & (msf_carrier_counter[DECIM_LOG2-1:0] == '0);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tap_sr <= '0;
    else     tap_sr <= (tap_sr << 1) | WR_DELAY'(tap);
  end

  assign write_second_bram = {BE_W{tap_sr[WR_DELAY-1]}};
  assign write_minute_bram = {BE_W{min_we}};

  assign match    = (msf_carrier_counter == low_time);
  assign tick_now = (state == IDLE) && match;

`ifdef MINUTE_SYNC_EN
  logic sync_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              sync_pending <= 1'b0;
    else if (tick_now)    sync_pending <= 1'b0;
    else if (minute_sync) sync_pending <= 1'b1;
  end

  assign sync_now = sync_pending | minute_sync;
`else
  assign sync_now = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    sec_nxt    = second_counter;
    marker_nxt = 1'b0;
    wrap_nxt   = 1'b0;
    min_we_nxt = min_we;
    if (!match) begin
      state_nxt  = IDLE;
      min_we_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = TICK;
          marker_nxt = 1'b1;
          if (sync_now || (second_counter == SEC_LAST)) begin
            sec_nxt  = '0;
            wrap_nxt = 1'b1;
          end else begin
            sec_nxt = second_counter + 1'b1;
          end
        end
        TICK: begin
          state_nxt = WAIT;
          wait_nxt  = WAIT_LOAD;
        end
        // A count of 1 (or a zero load) is the last match cycle before the write.
        WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state_nxt  = WRITE;
            wait_nxt   = '0;
            min_we_nxt = 1'b1;
          end else begin
            wait_nxt = wait_cnt - 4'd1;
          end
        end
        WRITE: begin
          state_nxt  = HOLD;
          min_we_nxt = 1'b0;
        end
        HOLD:    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      second_counter <= '0;
      one_sec_marker <= 1'b0;
      minute_wrap    <= 1'b0;
      min_we         <= 1'b0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_nxt;
      second_counter <= sec_nxt;
      one_sec_marker <= marker_nxt;
      minute_wrap    <= wrap_nxt;
      min_we         <= min_we_nxt;
    end
  end

endmodule

// File: tb/tb_timing_control_gen2.sv
// Self-checking bench for timing_control_gen2: vector table, hand-written corner sequences and
// randomized traffic against a run-length reference model. Covers `MINUTE_SYNC_EN when defined.
module tb_timing_control_gen2;

  localparam int CNT_W = 17;
  localparam int SEC_W = 6;
  localparam int SM    = 59;
  localparam int DECIM = 2;
  localparam int WRD   = 3;
  localparam int MIND  = 4;
  localparam int BE_W  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             msf_carrier_pulse = 1'b0;
  logic             minute_sync = 1'b0;
  logic [CNT_W-1:0] msf_frequency;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W-1:0] msf_carrier_counter;
  logic [SEC_W-1:0] second_counter;
  logic             one_sec_marker;
  logic             minute_wrap;
  logic [BE_W-1:0]  write_second_bram;
  logic [BE_W-1:0]  write_minute_bram;

  timing_control_gen2 #(.DECIM_LOG2(DECIM)) dut (
    .clk                 (clk),
    .rst                 (rst),
`ifdef MINUTE_SYNC_EN
    .minute_sync         (minute_sync),
`endif
    .msf_carrier_pulse   (msf_carrier_pulse),
    .msf_frequency       (msf_frequency),
    .low_time            (low_time),
    .msf_carrier_counter (msf_carrier_counter),
    .second_counter      (second_counter),
    .one_sec_marker      (one_sec_marker),
    .minute_wrap         (minute_wrap),
    .write_second_bram   (write_second_bram),
    .write_minute_bram   (write_minute_bram)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: match run length decides tick and minute write, a due-cycle queue the second write.
  int m_cnt, m_sec, m_run, cyc;
  bit m_marker, m_wrap, m_secwr, m_minwr, m_pend;
  int due_q[$];

  typedef struct {
    int exp_cnt;
    int exp_ticks;
    int exp_sec;
  } wrap_vec_t;

  wrap_vec_t wrap_tab[13];

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sec = 0; m_run = 0;
    m_marker = 0; m_wrap = 0; m_secwr = 0; m_minwr = 0; m_pend = 0;
    due_q.delete();
  endtask

  task automatic model_step(input bit p, input bit sync);
    bit match_now, tap_now, sync_now;
    cyc++;
    match_now = (m_cnt == int'(low_time));
    tap_now   = p && ((m_cnt % (1 << DECIM)) == 0);
    if (tap_now) due_q.push_back(cyc + WRD - 1);
    if (p) m_cnt = (m_cnt < int'(msf_frequency)) ? m_cnt + 1 : 0;
    m_run    = match_now ? ((m_run < 1000) ? m_run + 1 : 1000) : 0;
    m_marker = (m_run == 1);
    m_minwr  = (m_run == MIND + 1);
    m_wrap   = 0;
`ifdef MINUTE_SYNC_EN
    sync_now = m_pend || sync;
`else
    sync_now = 0;
`endif
    if (m_run == 1) begin
      if (sync_now) begin
        m_sec = 0; m_wrap = 1; m_pend = 0;
      end else begin
        m_sec  = (m_sec + 1) % (SM + 1);
        m_wrap = (m_sec == 0);
      end
    end else if (sync) begin
      m_pend = 1;
    end
    m_secwr = 0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      m_secwr = 1;
      void'(due_q.pop_front());
    end
  endtask

  task automatic check_output();
    check_val("msf_carrier_counter", int'(msf_carrier_counter), m_cnt);
    check_val("second_counter", int'(second_counter), m_sec);
    check_val("one_sec_marker", int'(one_sec_marker), int'(m_marker));
    check_val("minute_wrap", int'(minute_wrap), int'(m_wrap));
    check_val("write_second_bram", int'(write_second_bram), m_secwr ? 15 : 0);
    check_val("write_minute_bram", int'(write_minute_bram), m_minwr ? 15 : 0);
  endtask

  // One clock: drive at negedge, model the posedge, compare at the next negedge.
  task automatic apply_stimulus(input bit p);
    msf_carrier_pulse = p;
    @(posedge clk);
    model_step(p, minute_sync);
    @(negedge clk);
    check_output();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_val("rst_counter", int'(msf_carrier_counter), 0);
    check_val("rst_second", int'(second_counter), 0);
    check_val("rst_marker", int'(one_sec_marker), 0);
    check_val("rst_wrap", int'(minute_wrap), 0);
    check_val("rst_wr_second", int'(write_second_bram), 0);
    check_val("rst_wr_minute", int'(write_minute_bram), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ticks, minwr, found, prev_sec;

    for (int g = 0; g < 13; g++) begin
      wrap_tab[g].exp_cnt   = (g + 1) % 10;
      wrap_tab[g].exp_ticks = (g == 2 || g == 12) ? 1 : 0;
      wrap_tab[g].exp_sec   = (g < 2) ? 0 : ((g < 12) ? 1 : 2);
    end

    cyc = 0;
    model_reset();
    msf_frequency = CNT_W'(9);
    low_time      = CNT_W'(3);
    @(negedge clk);
    do_reset();

    // Counter wrap: one pulse every 4 clocks, freq 9, low 3.
    for (int g = 0; g < 13; g++) begin
      ticks = 0;
      apply_stimulus(1'b1);
      ticks += int'(one_sec_marker);
      for (int k = 0; k < 3; k++) begin
        apply_stimulus(1'b0);
        ticks += int'(one_sec_marker);
      end
      check_val($sformatf("wrap_cnt[%0d]", g), int'(msf_carrier_counter), wrap_tab[g].exp_cnt);
      check_val($sformatf("wrap_ticks[%0d]", g), ticks, wrap_tab[g].exp_ticks);
      check_val($sformatf("wrap_sec[%0d]", g), int'(second_counter), wrap_tab[g].exp_sec);
    end

    // Held match for 8 cycles: one tick, minute write only on the 5th cycle after onset.
    low_time = CNT_W'(4);
    apply_stimulus(1'b1);
    ticks = 0;
    for (int i = 1; i <= 8; i++) begin
      apply_stimulus(1'b0);
      ticks += int'(one_sec_marker);
      check_val($sformatf("held_wr_minute[%0d]", i), int'(write_minute_bram), (i == 5) ? 15 : 0);
    end
    check_val("held_ticks", ticks, 1);
    check_val("held_sec", int'(second_counter), 3);

    // Match lasting 3 cycles: tick but no minute write.
    low_time = CNT_W'(5);
    ticks = 0;
    minwr = 0;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus((i == 0 || i == 3) ? 1'b1 : 1'b0);
      ticks += int'(one_sec_marker);
      minwr += (write_minute_bram != '0) ? 1 : 0;
    end
    check_val("short_ticks", ticks, 1);
    check_val("short_minwr", minwr, 0);

    // Minute wrap: 59 -> 0 with minute_wrap and one_sec_marker together.
    msf_frequency = CNT_W'(1);
    low_time      = CNT_W'(0);
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      prev_sec = int'(second_counter);
      apply_stimulus(1'b1);
      if (m_wrap) begin
        found = 1;
        check_val("mwrap_prev_sec", prev_sec, 59);
        check_val("mwrap_sec", int'(second_counter), 0);
        check_val("mwrap_wrap", int'(minute_wrap), 1);
        check_val("mwrap_marker", int'(one_sec_marker), 1);
        apply_stimulus(1'b1);
        check_val("mwrap_wrap_after", int'(minute_wrap), 0);
      end
    end
    check_val("mwrap_found", found, 1);

    // Decimation: taps at counter 0,4,8,.. appear 3 cycles later.
    msf_frequency = CNT_W'(100);
    low_time      = CNT_W'(100);
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1'b1);
      check_val($sformatf("decim_wr[%0d]", i), int'(write_second_bram), ((i % 4) == 3) ? 15 : 0);
    end

    // Reset mid-operation with counter 1234, second 17 and minute write high.
    msf_frequency = CNT_W'(1);
    low_time      = CNT_W'(0);
    for (int i = 0; i < 200 && m_sec != 16; i++) apply_stimulus(1'b1);
    check_val("mid_sec16", m_sec, 16);
    msf_frequency = CNT_W'(2000);
    low_time      = CNT_W'(1234);
    for (int i = 0; i < 3000 && m_cnt != 1234; i++) apply_stimulus(1'b1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0);
    check_val("mid_counter", int'(msf_carrier_counter), 1234);
    check_val("mid_sec", int'(second_counter), 17);
    check_val("mid_wr_minute", int'(write_minute_bram), 15);
    do_reset();
    msf_frequency = CNT_W'(9);
    low_time      = CNT_W'(3);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      apply_stimulus(1'b1);
      if (m_marker) begin
        found = 1;
        check_val("post_rst_sec", int'(second_counter), 1);
        check_val("post_rst_marker", int'(one_sec_marker), 1);
      end
    end
    check_val("post_rst_found", found, 1);

`ifdef MINUTE_SYNC_EN
    // Sync at second 17: next tick loads 0 with minute_wrap, the one after gives 1.
    msf_frequency = CNT_W'(1);
    low_time      = CNT_W'(0);
    for (int i = 0; i < 200 && m_sec != 17; i++) apply_stimulus(1'b1);
    check_val("sync_at17", int'(second_counter), 17);
    minute_sync = 1'b1;
    apply_stimulus(1'b1);
    minute_sync = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      apply_stimulus(1'b1);
      if (m_marker) found = 1;
    end
    check_val("sync_found", found, 1);
    check_val("sync_sec", int'(second_counter), 0);
    check_val("sync_wrap", int'(minute_wrap), 1);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      apply_stimulus(1'b1);
      if (m_marker) found = 1;
    end
    check_val("sync_next_sec", int'(second_counter), 1);
    check_val("sync_next_wrap", int'(minute_wrap), 0);
`endif

    // Randomized traffic, including lowering msf_frequency below the current count.
    for (int i = 0; i < 600; i++) begin
      if ((i % 50) == 0) begin
        msf_frequency = CNT_W'($urandom_range(2, 30));
        low_time      = CNT_W'($urandom_range(0, 32'(msf_frequency)));
      end
`ifdef MINUTE_SYNC_EN
      minute_sync = ($urandom_range(0, 40) == 0);
`endif
      apply_stimulus($urandom_range(0, 3) != 0);
    end
    minute_sync = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timing_control_gen2.md
Name: timing_control_gen2

Overview:
- Parametrised successor to the MSF/DCF carrier timing controller.
- Counts received carrier pulses into a per-second phase counter. This counter is the address for the second BRAM.
- Derives a second tick and a 0..SECONDS_MINUTE second counter. The second counter is the address for the minute BRAM.
- Generates decimated, delayed byte-enable write strobes for both BRAMs.
- Sits between the carrier pulse detector and the second/minute capture memories, in the ADC clock domain.

Parameters:
- CNT_W, 17: width of the carrier counter, msf_frequency and low_time.
- SEC_W, 6: width of second_counter.
- SECONDS_MINUTE, 59: last second index before wrap.
- DECIM_LOG2, 10: the second BRAM is written on every 2^DECIM_LOG2-th carrier pulse. 0 means every pulse.
- WR_DELAY, 3: cycles from the qualifying pulse to write_second_bram. Legal range is 1..15.
- MIN_WR_DELAY, 4: consecutive match cycles after the tick before the minute write. Legal range is 1..15.
- BE_W, 4: byte-enable width of both write strobes.

Ports:
- clk  in  1  ADC sample clock (adc_clk).
- rst  in  1  Asynchronous, active-high reset.
- msf_carrier_pulse  in  1  One-cycle carrier pulse.
- msf_frequency  in  CNT_W  Terminal count for the carrier counter (pulses per second minus 1).
- low_time  in  CNT_W  Carrier count at which the second boundary is declared.
- msf_carrier_counter  out  CNT_W  Carrier phase within the second; second-BRAM address.
- second_counter  out  SEC_W  Second index 0..SECONDS_MINUTE; minute-BRAM address.
- one_sec_marker  out  1  One-cycle pulse on each second tick.
- minute_wrap  out  1  One-cycle pulse when second_counter returns to 0.
- write_second_bram  out  BE_W  All-ones for one cycle per decimated pulse, otherwise 0.
- write_minute_bram  out  BE_W  All-ones for one cycle per second, otherwise 0.
- minute_sync  in  1  Only present with MINUTE_SYNC_EN; see Optional Feature.

Behaviour:
- Reset: every output and internal register is cleared to 0, and the FSM goes to IDLE. The reset is asynchronous, so it takes effect mid-second with no partial strobe afterwards.
- Carrier counter update, on a clk edge with msf_carrier_pulse=1:
  - If counter < msf_frequency, counter increments.
  - Otherwise counter becomes 0. This includes counter > msf_frequency after msf_frequency is lowered.
  - With no pulse, the counter holds.
- Second-write tap:
  - tap = msf_carrier_pulse & (counter[DECIM_LOG2-1:0]==0), evaluated on the pre-increment counter. When DECIM_LOG2=0 the tap equals msf_carrier_pulse.
  - The tap passes through a WR_DELAY-stage shift register. write_second_bram replicates the last stage across BE_W bits.
- match = (msf_carrier_counter == low_time), using the registered counter.
- FSM states: IDLE, TICK, WAIT, WRITE, HOLD.
  - IDLE & match: go to TICK. On the same edge:
    - second_counter becomes second_counter+1, or 0 if it equals SECONDS_MINUTE.
    - one_sec_marker is registered 1.
    - minute_wrap is registered 1 on the wrap.
  - TICK & match: go to WAIT and load wait count = MIN_WR_DELAY-1.
  - WAIT & match: decrement the wait count. When it reaches 0, go to WRITE and register write_minute_bram all-ones.
  - WRITE & match: go to HOLD and clear write_minute_bram.
  - HOLD & match: stay in HOLD. A held match never re-ticks.
  - Any state & !match: go to IDLE and clear write_minute_bram.
- one_sec_marker and minute_wrap are high for exactly the one cycle after the tick edge.
- Minute write timing: with MIN_WR_DELAY=4, write_minute_bram is visible during the 5th cycle after match first goes true. If match drops earlier, the minute write is skipped for that second.
- Second tick and second-write tap on the same edge: both act independently.

Optional Feature:
- Macro: MINUTE_SYNC_EN.
- Defined:
  - Adds the minute_sync input.
  - A minute_sync=1 on any edge sets a pending flag.
  - On the next tick, second_counter loads 0 instead of advancing, minute_wrap pulses, and the pending flag clears.
  - minute_sync coincident with a tick applies to that tick.
  - Reset clears the pending flag.
- Undefined: the port is absent and second_counter free-runs modulo SECONDS_MINUTE+1.

Test Plan:
- Reset mid-operation: assert rst while counter=1234, second=17 and write_minute_bram is high. All outputs go to 0 immediately. After release, the first tick gives second_counter=1.
- Wrap: msf_frequency=9, low_time=3, one pulse every 4 clks. The counter sequence is 0..9,0. one_sec_marker fires once per 10 pulses, as match first occurs. second_counter increments per tick.
- Minute wrap, SECONDS_MINUTE=59: after 60 ticks, second_counter goes 59 to 0. minute_wrap and one_sec_marker are high in the same single cycle.
- Held match: pulses stopped with counter=low_time for 8 cycles. Result:
  - exactly one tick;
  - write_minute_bram=4'hF for exactly 1 cycle, 5 cycles after match onset;
  - a match of only 3 cycles gives no minute write.
- Decimation, DECIM_LOG2=2, WR_DELAY=3, a pulse every clk: write_second_bram=4'hF exactly 3 cycles after each pulse taken with counter[1:0]=0, and is 0 otherwise.
- Sync, MINUTE_SYNC_EN defined: minute_sync pulses while second_counter=17. The next tick gives second_counter=0 with minute_wrap=1. The following tick gives 1.
